// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32I datapath. It sequences fetch, decode, execute,
// memory and writeback, drives every mux select and write strobe, and counts retired instructions.
module multicycle_ctrl #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          Instr,
    input  logic                 Zero,
    input  logic                 mem_ready,
    output logic                 MemReq,
    output logic                 MemWrite,
    output logic                 AdrSrc,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [3:0]           ALUControl,
    output logic [2:0]           ImmSrc,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
        S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR2, S_UPPER, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                           ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_SLT = 4'b0101,
                           ALU_SLTU = 4'b0110, ALU_SLL = 4'b0111, ALU_SRL = 4'b1000,
                           ALU_SRA = 4'b1001;

    state_t     state, next_state;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       retire;
    logic       unused_instr;

    assign opcode       = Instr[6:0];
    assign funct3       = Instr[14:12];
    assign funct7b5     = Instr[30];
    assign unused_instr = ^{Instr[31], Instr[29:15], Instr[11:7]};

    // Register-register ops use funct7b5 for SUB; immediate ops only for SRAI.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7b5,
                                              input logic is_reg);
        case (f3)
            3'b000:  alu_decode = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_decode = ALU_SLL;
            3'b010:  alu_decode = ALU_SLT;
            3'b011:  alu_decode = ALU_SLTU;
            3'b100:  alu_decode = ALU_XOR;
            3'b101:  alu_decode = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_decode = ALU_OR;
            default: alu_decode = ALU_AND;
        endcase
    endfunction

    function automatic logic [3:0] branch_alu(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001: branch_alu = ALU_SUB;
            3'b100, 3'b101: branch_alu = ALU_SLT;
            3'b110, 3'b111: branch_alu = ALU_SLTU;
            default:        branch_alu = ALU_ADD;
        endcase
    endfunction

    // Zero set means equal (SUB) or "not less than" (SLT/SLTU result of 0).
    function automatic logic branch_taken(input logic [2:0] f3, input logic z);
        case (f3)
            3'b000, 3'b101, 3'b111: branch_taken = z;
            3'b001, 3'b100, 3'b110: branch_taken = ~z;
            default:                branch_taken = 1'b0;
        endcase
    endfunction

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:    if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_REG:            next_state = S_EXECR;
                    OP_IMM:            next_state = S_EXECI;
                    OP_BR:             next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_LUI, OP_AUIPC:  next_state = S_UPPER;
                    default:           next_state = S_TRAP;
                endcase
            end
            S_MEMADR:   next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
            S_EXECR,
            S_EXECI:    next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BRANCH:   next_state = (funct3 == 3'b010 || funct3 == 3'b011) ? S_TRAP : S_FETCH;
            S_JAL:      next_state = S_ALUWB;
            S_JALR:     next_state = S_JALR2;
            S_JALR2:    next_state = S_ALUWB;
            S_UPPER:    next_state = S_FETCH;
            default:    next_state = S_TRAP;
        endcase
    end

    // Retirement is the transition back to FETCH from a final state; FETCH holding itself never counts.
    assign retire = (next_state == S_FETCH) &&
                    (state == S_MEMWB || state == S_MEMWRITE || state == S_ALUWB ||
                     state == S_BRANCH || state == S_UPPER);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_FETCH;
            instret <= '0;
        end else begin
            state <= next_state;
            if (retire) instret <= instret + INSTRET_W'(1);
        end
    end

    always_comb begin
        case (opcode)
            OP_STORE:         ImmSrc = 3'b001;
            OP_BR:            ImmSrc = 3'b010;
            OP_JAL:           ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
            default:          ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        MemReq     = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                MemReq    = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
            S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
            S_MEMREAD:  begin MemReq = 1'b1; AdrSrc = 1'b1; end
            S_MEMWB:    begin ResultSrc = 2'b01; RegWrite = 1'b1; end
            S_MEMWRITE: begin MemReq = 1'b1; MemWrite = 1'b1; AdrSrc = 1'b1; end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_decode(funct3, funct7b5, 1'b1);
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_decode(funct3, funct7b5, 1'b0);
            end
            S_ALUWB:    RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = branch_alu(funct3);
                PCWrite    = branch_taken(funct3, Zero);
            end
            S_JAL, S_JALR2: begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCWrite = 1'b1; end
            S_JALR:     begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
            S_UPPER: begin
                RegWrite  = 1'b1;
                ResultSrc = (opcode == OP_LUI) ? 2'b11 : 2'b00;
            end
            S_TRAP:     illegal = 1'b1;
            default:    ;
        endcase
        // Reset lands in FETCH, whose request must not leak out while reset is still high.
        if (reset) begin
            MemReq   = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle control vectors for each instruction class,
// stalls, reset behaviour, trap handling and counter wrap on a narrow second instance.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic        Zero;
    logic        mem_ready;
    logic        MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
    logic [3:0]  ALUControl;
    logic [2:0]  ImmSrc;
    logic [31:0] instret;

    logic        w_MemReq, w_MemWrite, w_AdrSrc, w_IRWrite, w_PCWrite, w_RegWrite, w_illegal;
    logic [1:0]  w_ResultSrc, w_ALUSrcA, w_ALUSrcB;
    logic [3:0]  w_ALUControl;
    logic [2:0]  w_ImmSrc;
    logic [1:0]  w_instret;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_instret;
    logic [16:0] ctl;
    logic [16:0] F0, F1, DEC, MADR, MRD, MWB, MWR, AWB, TRP;

    always #5 clk = ~clk;

    multicycle_ctrl #(.INSTRET_W(32)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .Zero(Zero), .mem_ready(mem_ready),
        .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal),
        .instret(instret)
    );

    multicycle_ctrl #(.INSTRET_W(2)) dut_w (
        .clk(clk), .reset(reset), .Instr(Instr), .Zero(Zero), .mem_ready(mem_ready),
        .MemReq(w_MemReq), .MemWrite(w_MemWrite), .AdrSrc(w_AdrSrc), .IRWrite(w_IRWrite),
        .PCWrite(w_PCWrite), .RegWrite(w_RegWrite), .ResultSrc(w_ResultSrc),
        .ALUSrcA(w_ALUSrcA), .ALUSrcB(w_ALUSrcB), .ALUControl(w_ALUControl),
        .ImmSrc(w_ImmSrc), .illegal(w_illegal), .instret(w_instret)
    );

    assign ctl = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ALUControl, illegal};

    function automatic logic [16:0] pk(input logic mr, mw, adr, irw, pcw, rw,
                                       input logic [1:0] rs, a, b,
                                       input logic [3:0] alu, input logic ill);
        return {mr, mw, adr, irw, pcw, rw, rs, a, b, alu, ill};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b0; Zero = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_instret = 0;
    endtask

    // Stalled FETCH cycle that also confirms the retired count.
    task automatic end_check(input string name);
        @(negedge clk); mem_ready = 1'b0; #1;
        checks++;
        if (ctl !== F0) begin errors++; $display("FAIL %s end fetch: ctl=%h expected %h", name, ctl, F0); end
        checks++;
        if (instret !== exp_instret) begin
            errors++; $display("FAIL %s instret: got %0d expected %0d", name, instret, exp_instret);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; Instr = 32'h0; Zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({MemReq, MemWrite, IRWrite, PCWrite, RegWrite} !== 5'b0) begin
            errors++; $display("FAIL reset strobes: got %b expected 00000", {MemReq, MemWrite, IRWrite, PCWrite, RegWrite});
        end
        checks++;
        if (instret !== 32'd0 || illegal !== 1'b0) begin
            errors++; $display("FAIL reset state: instret=%0d illegal=%b expected 0/0", instret, illegal);
        end
        @(negedge clk); reset = 1'b0; mem_ready = 1'b0; #1;
        checks++;
        if (ctl !== F0) begin errors++; $display("FAIL reset release fetch: ctl=%h expected %h", ctl, F0); end
        exp_instret = 0;
    endtask

    task automatic test_reset_mid_store();
        logic [16:0] e [5];
        logic        r [5];
        e = '{F1, DEC, MADR, MWR, MWR};
        r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        Instr = 32'h0020A023;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); mem_ready = r[i]; #1;
            checks++;
            if (ctl !== e[i]) begin errors++; $display("FAIL store step %0d: ctl=%h expected %h", i, ctl, e[i]); end
        end
        checks++;
        if (ImmSrc !== 3'b001) begin errors++; $display("FAIL store immsrc: got %b expected 001", ImmSrc); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({MemReq, MemWrite} !== 2'b00) begin
            errors++; $display("FAIL mid-store reset: MemReq/MemWrite=%b expected 00", {MemReq, MemWrite});
        end
        @(negedge clk); reset = 1'b0; #1;
        exp_instret = 0;
        checks++;
        if (ctl !== F0 || instret !== 32'd0) begin
            errors++; $display("FAIL store post-reset: ctl=%h instret=%0d expected %h/0", ctl, instret, F0);
        end
    endtask

    task automatic test_add();
        logic [16:0] e [4];
        e = '{F1, DEC, pk(0,0,0,0,0,0,2'b00,2'b10,2'b00,4'b0000,0), AWB};
        Instr = 32'h002081B3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ready = 1'b1; #1;
            checks++;
            if (ctl !== e[i]) begin errors++; $display("FAIL add step %0d: ctl=%h expected %h", i, ctl, e[i]); end
        end
        exp_instret++;
        end_check("add");
    endtask

    task automatic test_lw();
        logic [16:0] e [10];
        logic        r [10];
        e = '{F0, F0, F1, DEC, MADR, MRD, MRD, MRD, MRD, MWB};
        r = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        Instr = 32'h0000A183;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); mem_ready = r[i]; #1;
            checks++;
            if (ctl !== e[i]) begin errors++; $display("FAIL lw step %0d: ctl=%h expected %h", i, ctl, e[i]); end
            if (i == 3) begin
                checks++;
                if (ImmSrc !== 3'b000) begin errors++; $display("FAIL lw immsrc: got %b expected 000", ImmSrc); end
            end
        end
        exp_instret++;
        end_check("lw");
    endtask

    task automatic test_bne();
        logic [16:0] e [3];
        Instr = 32'h00209463;
        for (int z = 1; z >= 0; z--) begin
            e = '{F1, DEC, pk(0,0,0,0,logic'(z == 0),0,2'b00,2'b10,2'b00,4'b0001,0)};
            for (int i = 0; i < 3; i++) begin
                @(negedge clk); mem_ready = 1'b1; Zero = logic'(z); #1;
                checks++;
                if (ctl !== e[i]) begin
                    errors++; $display("FAIL bne zero=%0d step %0d: ctl=%h expected %h", z, i, ctl, e[i]);
                end
                if (i == 1) begin
                    checks++;
                    if (ImmSrc !== 3'b010) begin errors++; $display("FAIL bne immsrc: got %b expected 010", ImmSrc); end
                end
            end
            exp_instret++;
        end
        Zero = 1'b0;
        end_check("bne");
    endtask

    task automatic test_jumps();
        logic [16:0] jr [5];
        logic [16:0] jl [4];
        jr = '{F1, DEC, pk(0,0,0,0,0,0,2'b00,2'b10,2'b01,4'b0000,0),
               pk(0,0,0,0,1,0,2'b00,2'b01,2'b10,4'b0000,0), AWB};
        jl = '{F1, DEC, pk(0,0,0,0,1,0,2'b00,2'b01,2'b10,4'b0000,0), AWB};
        Instr = 32'h000080E7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); mem_ready = 1'b1; #1;
            checks++;
            if (ctl !== jr[i]) begin errors++; $display("FAIL jalr step %0d: ctl=%h expected %h", i, ctl, jr[i]); end
        end
        exp_instret++;
        end_check("jalr");
        Instr = 32'h008000EF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_ready = 1'b1; #1;
            checks++;
            if (ctl !== jl[i]) begin errors++; $display("FAIL jal step %0d: ctl=%h expected %h", i, ctl, jl[i]); end
            if (i == 1) begin
                checks++;
                if (ImmSrc !== 3'b011) begin errors++; $display("FAIL jal immsrc: got %b expected 011", ImmSrc); end
            end
        end
        exp_instret++;
        end_check("jal");
    endtask

    task automatic test_alu_decode();
        logic [31:0] ins [9];
        logic [3:0]  alu [9];
        logic [16:0] ex;
        ins = '{32'h402081B3, 32'h4020D1B3, 32'h0020A1B3, 32'h0020B1B3, 32'h0020F1B3,
                32'h4010D193, 32'hC0008193, 32'h0030E193, 32'h0010D193};
        alu = '{4'b0001, 4'b1001, 4'b0101, 4'b0110, 4'b0010,
                4'b1001, 4'b0000, 4'b0011, 4'b1000};
        for (int k = 0; k < 9; k++) begin
            Instr = ins[k];
            ex = pk(0,0,0,0,0,0,2'b00,2'b10,(k < 5) ? 2'b00 : 2'b01, alu[k], 0);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk); mem_ready = 1'b1; #1;
                if (i == 2) begin
                    checks++;
                    if (ctl !== ex) begin
                        errors++; $display("FAIL alu %h exec: ctl=%h expected %h", ins[k], ctl, ex);
                    end
                end
            end
            exp_instret++;
        end
        end_check("alu");
    endtask

    task automatic test_upper();
        Instr = 32'h123451B7;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk); mem_ready = 1'b1; #1;
            end
            checks++;
            if (ctl !== pk(0,0,0,0,0,1,(k == 0) ? 2'b11 : 2'b00,2'b00,2'b00,4'b0000,0) || ImmSrc !== 3'b100) begin
                errors++; $display("FAIL upper %0d: ctl=%h immsrc=%b expected RegWrite with ResultSrc %s, immsrc 100",
                                   k, ctl, ImmSrc, (k == 0) ? "11" : "00");
            end
            exp_instret++;
            Instr = 32'h12345197;
        end
        end_check("upper");
    endtask

    task automatic test_wrap();
        do_reset();
        Instr = 32'h123451B7;
        for (int k = 1; k <= 4; k++) begin
            repeat (3) begin @(negedge clk); mem_ready = 1'b1; #1; end
            exp_instret++;
            if (k >= 3) begin
                @(negedge clk); mem_ready = 1'b0; #1;
                checks++;
                if (w_instret !== exp_instret[1:0]) begin
                    errors++; $display("FAIL wrap after %0d: narrow instret=%0d expected %0d", k, w_instret, exp_instret[1:0]);
                end
            end
        end
        end_check("wrap");
    endtask

    task automatic test_trap();
        logic [16:0] e [6];
        logic [16:0] bil;
        bil = pk(0,0,0,0,0,0,2'b00,2'b10,2'b00,4'b0000,0);
        e = '{F1, DEC, bil, TRP, TRP, TRP};
        Instr = 32'h0020A063;
        Zero = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); mem_ready = 1'b1; #1;
            checks++;
            if (ctl !== e[i]) begin errors++; $display("FAIL branch-trap step %0d: ctl=%h expected %h", i, ctl, e[i]); end
        end
        checks++;
        if (instret !== exp_instret) begin
            errors++; $display("FAIL branch-trap instret: got %0d expected %0d", instret, exp_instret);
        end
        do_reset();
        Instr = 32'hFFFFFFFF;
        Zero = 1'b0;
        @(negedge clk); mem_ready = 1'b1; #1;
        @(negedge clk); mem_ready = 1'b0; #1;
        checks++;
        if (ctl !== DEC) begin errors++; $display("FAIL illegal decode: ctl=%h expected %h", ctl, DEC); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); mem_ready = logic'(i % 2); Zero = logic'(i % 3 == 0); #1;
            checks++;
            if (ctl !== TRP || instret !== exp_instret) begin
                errors++; $display("FAIL trap cycle %0d: ctl=%h instret=%0d expected %h/%0d", i, ctl, instret, TRP, exp_instret);
            end
        end
        do_reset();
        @(negedge clk); #1;
        checks++;
        if (ctl !== F0 || instret !== 32'd0) begin
            errors++; $display("FAIL trap exit reset: ctl=%h instret=%0d expected %h/0", ctl, instret, F0);
        end
    endtask

    initial begin
        F0   = pk(1,0,0,0,0,0,2'b10,2'b00,2'b10,4'b0000,0);
        F1   = pk(1,0,0,1,1,0,2'b10,2'b00,2'b10,4'b0000,0);
        DEC  = pk(0,0,0,0,0,0,2'b00,2'b01,2'b01,4'b0000,0);
        MADR = pk(0,0,0,0,0,0,2'b00,2'b10,2'b01,4'b0000,0);
        MRD  = pk(1,0,1,0,0,0,2'b00,2'b00,2'b00,4'b0000,0);
        MWB  = pk(0,0,0,0,0,1,2'b01,2'b00,2'b00,4'b0000,0);
        MWR  = pk(1,1,1,0,0,0,2'b00,2'b00,2'b00,4'b0000,0);
        AWB  = pk(0,0,0,0,0,1,2'b00,2'b00,2'b00,4'b0000,0);
        TRP  = pk(0,0,0,0,0,0,2'b00,2'b00,2'b00,4'b0000,1);
        exp_instret = 0;
        test_reset();
        test_reset_mid_store();
        test_add();
        test_lw();
        test_bne();
        test_jumps();
        test_alu_decode();
        test_upper();
        test_wrap();
        test_trap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
